dmem_responder: RTL and testbench

Data-memory responder for the riscv_pipeline memory stage. The pipeline issues load/store requests; this block accepts them with a valid/ready handshake and applies a configurable access latency. It performs byte/half/word accesses selected by funct3 and returns sign- or zero-extended load data, or an error, as a one-cycle response. It also drives a stall signal that the hazard unit ORs into StallF/StallD and the M-stage hold.

---
 rtl/riscv_mem_pkg.sv | 15 +
 rtl/lsu_align.sv | 63 ++++++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants for the riscv_pipeline memory stage: funct3 access codes
// and the data-memory responder state encoding.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane logic: access-error detection, store byte
// mask and replicated lane data, load extraction with sign/zero extension.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdWord,
  output logic        accessErr,
  output logic [3:0]  wmask,
  output logic [31:0] wlanes,
  output logic [31:0] loadData
);

  logic [31:0] shifted;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    shifted = rdWord >> {lane, 3'b000};
    byteSel = shifted[7:0];
    halfSel = lane[1] ? rdWord[31:16] : rdWord[15:0];
  end

  always_comb begin
    accessErr = 1'b0;
    wmask     = 4'b0000;
    wlanes    = 32'h0;
    loadData  = 32'h0;
    case (funct3)
      F3_B: begin
        wmask    = 4'b0001 << lane;
        wlanes   = {4{wdata[7:0]}};
        loadData = {{24{byteSel[7]}}, byteSel};
      end
      F3_H: begin
        accessErr = lane[0];
        wmask     = lane[1] ? 4'b1100 : 4'b0011;
        wlanes    = {2{wdata[15:0]}};
        loadData  = {{16{halfSel[15]}}, halfSel};
      end
      F3_W: begin
        accessErr = (lane != 2'b00);
        wmask     = 4'b1111;
        wlanes    = wdata;
        loadData  = rdWord;
      end
      // Unsigned variants exist only for loads
      F3_BU: begin
        accessErr = we;
        loadData  = {24'h0, byteSel};
      end
      F3_HU: begin
        accessErr = we | lane[0];
        loadData  = {16'h0, halfSel};
      end
      default: accessErr = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// presents a one-cycle response while stalling the pipeline until then.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_stall
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]  stateReg;
  logic [3:0]  cntReg;
  logic        weReg;
  logic [31:0] addrReg;
  logic [31:0] wdataReg;
  logic [2:0]  funct3Reg;

  logic        accessErr;
  logic        rangeErr;
  logic        errFlag;
  logic        lastWait;
  logic [3:0]  wmask;
  logic [31:0] wlanes;
  logic [31:0] loadData;
  logic [IDX_W-1:0] wordIdx;
  wire  [31:0] rdWord;

  assign rangeErr = (addrReg[31:2] >= 30'(DEPTH_WORDS));
  assign errFlag  = accessErr | rangeErr;
  assign wordIdx  = addrReg[IDX_W+1:2];
  assign lastWait = (stateReg == WAIT) && (cntReg == 4'd1);

  assign req_ready = (stateReg == IDLE) && reset;
  assign mem_stall = reset && (((stateReg == IDLE) && req_valid) || (stateReg == WAIT));
  assign rsp_valid = (stateReg == RESP);
  assign rsp_err   = rsp_valid && errFlag;
  assign rsp_rdata = (rsp_valid && !errFlag && !weReg) ? loadData : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg  <= IDLE;
      cntReg    <= 4'd0;
      weReg     <= 1'b0;
      addrReg   <= 32'h0;
      wdataReg  <= 32'h0;
      funct3Reg <= 3'b000;
    end else begin
      case (stateReg)
        IDLE: begin
          if (req_valid && req_ready) begin
            weReg     <= req_we;
            addrReg   <= req_addr;
            wdataReg  <= req_wdata;
            funct3Reg <= req_funct3;
            cntReg    <= 4'(LATENCY);
            stateReg  <= WAIT;
          end
        end
        WAIT: begin
          cntReg <= cntReg - 4'd1;
          if (cntReg == 4'd1) stateReg <= RESP;
        end
        RESP:    stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  lsu_align u_align (
    .we        (weReg),
    .lane      (addrReg[1:0]),
    .funct3    (funct3Reg),
    .wdata     (wdataReg),
    .rdWord    (rdWord),
    .accessErr (accessErr),
    .wmask     (wmask),
    .wlanes    (wlanes),
    .loadData  (loadData)
  );

  // One byte-wide array per lane so each lane's write enable stays independent
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] laneMem [DEPTH_WORDS];
    logic [7:0] laneRdReg;

    always_ff @(posedge clk) begin
      if (lastWait && !errFlag) begin
        if (weReg) begin
          if (wmask[gi]) laneMem[wordIdx] <= wlanes[gi*8 +: 8];
        end else begin
          laneRdReg <= laneMem[wordIdx];
        end
      end
    end

    assign rdWord[gi*8 +: 8] = laneRdReg;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: handshake timing, lane access, errors,
// back-to-back throughput and reset during a pending store.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_stall;

  int passCnt = 0;
  int checkCnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_stall  (mem_stall)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request, scramble the inputs after accept, and check the response.
  task automatic doReq(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] expData, input logic expErr);
    int lat = 0;
    int stallCnt = 0;
    logic gotRsp = 1'b0;
    logic readyAfter = 1'b1;
    logic stallAtRsp = 1'b1;
    logic [31:0] data = 32'h0;
    logic err = 1'b0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    #1;
    checkVal({name, " ready"}, 32'(req_ready), 32'd1);
    checkVal({name, " stall@req"}, 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_funct3 = 3'b111; req_we = ~we;
    for (int i = 1; i <= 20 && !gotRsp; i++) begin
      @(negedge clk);
      if (i == 1) readyAfter = req_ready;
      if (rsp_valid) begin
        gotRsp = 1'b1; lat = i; data = rsp_rdata; err = rsp_err; stallAtRsp = mem_stall;
      end else if (mem_stall) begin
        stallCnt++;
      end
    end
    checkVal({name, " rsp seen"}, 32'(gotRsp), 32'd1);
    checkVal({name, " latency"}, 32'(lat), 32'(LAT + 1));
    checkVal({name, " stall cycles"}, 32'(stallCnt), 32'(LAT));
    checkVal({name, " ready after accept"}, 32'(readyAfter), 32'd0);
    checkVal({name, " stall@rsp"}, 32'(stallAtRsp), 32'd0);
    checkVal({name, " rdata"}, data, expData);
    checkVal({name, " err"}, 32'(err), 32'(expErr));
    @(negedge clk);
    checkVal({name, " rsp one cycle"}, 32'(rsp_valid), 32'd0);
    checkVal({name, " err cleared"}, 32'(rsp_err), 32'd0);
    $display("%-10s we=%0d addr=0x%08h f3=%03b -> rdata=0x%08h err=%0d lat=%0d",
             name, we, addr, f3, data, err, lat);
  endtask

  initial begin
    logic [8:0] readyBits;
    logic [8:0] rspBits;
    int rspCnt;

    // Reset state, with a request pending to confirm stall stays low
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("rst ready", 32'(req_ready), 32'd0);
    checkVal("rst rsp_valid", 32'(rsp_valid), 32'd0);
    checkVal("rst rdata", rsp_rdata, 32'h0);
    checkVal("rst err", 32'(rsp_err), 32'd0);
    checkVal("rst stall", 32'(mem_stall), 32'd0);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    doReq("sw", 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    doReq("lb", 1'b0, 32'h101, 32'h0, 3'b000, 32'hFFFFFFBE, 1'b0);
    doReq("lbu", 1'b0, 32'h103, 32'h0, 3'b100, 32'h000000DE, 1'b0);
    doReq("lhu", 1'b0, 32'h102, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);
    doReq("lh", 1'b0, 32'h100, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
    doReq("sb", 1'b1, 32'h101, 32'h00000012, 3'b000, 32'h0, 1'b0);
    doReq("lw sb", 1'b0, 32'h100, 32'h0, 3'b010, 32'hDEAD12EF, 1'b0);
    doReq("sh", 1'b1, 32'h102, 32'h00005678, 3'b001, 32'h0, 1'b0);
    doReq("lw sh", 1'b0, 32'h100, 32'h0, 3'b010, 32'h567812EF, 1'b0);

    doReq("lw misal", 1'b0, 32'h102, 32'h0, 3'b010, 32'h0, 1'b1);
    doReq("sw range", 1'b1, 32'h1000, 32'h11111111, 3'b010, 32'h0, 1'b1);
    doReq("sw f3=011", 1'b1, 32'h100, 32'h22222222, 3'b011, 32'h0, 1'b1);
    doReq("sh misal", 1'b1, 32'h101, 32'h33333333, 3'b001, 32'h0, 1'b1);
    doReq("sbu illeg", 1'b1, 32'h100, 32'h44444444, 3'b100, 32'h0, 1'b1);
    doReq("lw f3=110", 1'b0, 32'h100, 32'h0, 3'b110, 32'h0, 1'b1);
    doReq("lw unchg", 1'b0, 32'h100, 32'h0, 3'b010, 32'h567812EF, 1'b0);
    doReq("sw last", 1'b1, 32'hFFC, 32'h11223344, 3'b010, 32'h0, 1'b0);
    doReq("lw last", 1'b0, 32'hFFC, 32'h0, 3'b010, 32'h11223344, 1'b0);

    // Back-to-back: request held valid; accepts only every LAT+2 cycles
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h100; req_funct3 = 3'b010; req_valid = 1'b1;
    readyBits = '0; rspBits = '0; rspCnt = 0;
    for (int n = 0; n < 9; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      readyBits[n] = req_ready;
      rspBits[n] = rsp_valid;
      if (rsp_valid) begin
        rspCnt++;
        checkVal("b2b rdata", rsp_rdata, 32'h567812EF);
      end
    end
    req_valid = 1'b0;
    checkVal("b2b ready pattern", 32'(readyBits), 32'h111);
    checkVal("b2b rsp pattern", 32'(rspBits), 32'h088);
    $display("b2b        ready=%09b rsp=%09b responses=%0d", readyBits, rspBits, rspCnt);
    repeat (6) @(negedge clk);

    // Reset pulse while a store is waiting to commit
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkVal("rstmid in WAIT", 32'(mem_stall), 32'd1);
    reset = 1'b0;
    #1;
    checkVal("rstmid ready", 32'(req_ready), 32'd0);
    checkVal("rstmid stall", 32'(mem_stall), 32'd0);
    checkVal("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
    checkVal("rstmid rdata", rsp_rdata, 32'h0);
    checkVal("rstmid err", 32'(rsp_err), 32'd0);
    rspCnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rspCnt++;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) rspCnt++;
    end
    checkVal("rstmid no rsp", 32'(rspCnt), 32'd0);
    $display("rstmid     responses after reset pulse=%0d", rspCnt);
    doReq("lw rst", 1'b0, 32'h100, 32'h0, 3'b010, 32'h567812EF, 1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
